// File: rtl/fork_arbiter.sv
// fork_arbiter: central fork arbiter for the dining-philosophers table.
//
// Drains one philosopher event at a time from the shared event FIFO, tracks
// which seats are hungry and which are eating, and after every event runs a
// round-robin scan over all seats. Each hungry seat whose two forks are free
// gets a one-cycle may_eat pulse.
//
// Parameters:
//   N_PHILO    number of seats (>= 2); seat i uses fork i and fork (i+1)%N_PHILO
//   ID_W       width of the seat ID field in an event word (2**ID_W >= N_PHILO)
//
// Ports:
//   clk        clock, all state updates on the rising edge
//   reset      synchronous, active-low reset
//   evt_empty  event FIFO empty flag
//   evt_data   event word: [ID_W] = 1 hungry / 0 done, [ID_W-1:0] = seat ID
//   evt_rden   event FIFO read enable, one-cycle pulse
//   may_eat    one-cycle grant pulse per seat
//   eating     level, seat holds both forks
//   fork_busy  level, fork f is held by seat f or seat f-1
//   err        sticky protocol-error flag, cleared only by reset
//   grant_cnt  total grants issued (wrapping)
//
// Optional feature: define DPP_ARB_STATS_EN to build the grant counter;
// otherwise grant_cnt is tied to zero.
module fork_arbiter #(
  parameter int N_PHILO = 4,
  parameter int ID_W    = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               evt_empty,
  input  logic [ID_W:0]      evt_data,
  output logic               evt_rden,
  output logic [N_PHILO-1:0] may_eat,
  output logic [N_PHILO-1:0] eating,
  output logic [N_PHILO-1:0] fork_busy,
  output logic               err,
  output logic [15:0]        grant_cnt
);

  localparam int IDX_W = (N_PHILO > 2) ? $clog2(N_PHILO) : 1;
  localparam logic [IDX_W-1:0] LAST_K = IDX_W'(N_PHILO - 1);

  typedef enum logic [1:0] {IDLE, READ, DECODE, SCAN} state_t;

  state_t             r_state, w_state_nxt;
  logic               r_rden, w_rden_nxt;
  logic [N_PHILO-1:0] r_hungry, r_eating, r_may_eat, w_fork_busy;
  logic [IDX_W-1:0]   r_rr, r_k, w_p, w_pr, w_idx;
  logic               r_err;
  logic [ID_W-1:0]    w_id;
  logic               w_hungry_evt, w_id_ok, w_dec_err, w_grant;

  // Seat index arithmetic modulo N_PHILO; operands are always < N_PHILO.
  function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] a,
                                                input logic [IDX_W-1:0] b);
    int s;
    s = int'(a) + int'(b);
    if (s >= N_PHILO) s = s - N_PHILO;
    return IDX_W'(s);
  endfunction

  // Fork f is held by its right-hand owner (seat f) or left-hand owner (seat f-1).
  always_comb begin
    w_fork_busy = '0;
    for (int f = 0; f < N_PHILO; f++) begin
      w_fork_busy[f] = r_eating[f] | r_eating[(f + N_PHILO - 1) % N_PHILO];
    end
  end

  // Event decode: an illegal event only raises err and leaves the tables alone.
  always_comb begin
    w_id         = evt_data[ID_W-1:0];
    w_hungry_evt = evt_data[ID_W];
    w_id_ok      = int'(w_id) < N_PHILO;
    w_idx        = IDX_W'(w_id);
    w_dec_err    = !w_id_ok ||
                   (w_hungry_evt ? (r_hungry[w_idx] | r_eating[w_idx]) : !r_eating[w_idx]);
  end

  // Scan uses the live fork_busy, so grants made earlier in the same scan
  // (already registered into r_eating) block later neighbours.
  always_comb begin
    w_p     = wrap_add(r_rr, r_k);
    w_pr    = wrap_add(w_p, IDX_W'(1));
    w_grant = (r_state == SCAN) && r_hungry[w_p] && !w_fork_busy[w_p] && !w_fork_busy[w_pr];
  end

  always_comb begin
    w_state_nxt = r_state;
    w_rden_nxt  = 1'b0;
    case (r_state)
      IDLE: begin
        if (!evt_empty) begin
          w_state_nxt = READ;
          w_rden_nxt  = 1'b1;
        end
      end
      READ:    w_state_nxt = DECODE;
      DECODE:  w_state_nxt = SCAN;
      SCAN:    if (r_k == LAST_K) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_rden    <= 1'b0;
      r_hungry  <= '0;
      r_eating  <= '0;
      r_may_eat <= '0;
      r_rr      <= '0;
      r_k       <= '0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_rden    <= w_rden_nxt;
      r_may_eat <= '0;
      if (r_state == DECODE) begin
        r_k <= '0;
        if (w_dec_err)         r_err           <= 1'b1;
        else if (w_hungry_evt) r_hungry[w_idx] <= 1'b1;
        else                   r_eating[w_idx] <= 1'b0;
      end
      if (r_state == SCAN) begin
        r_k <= r_k + 1'b1;
        if (w_grant) begin
          r_hungry[w_p]  <= 1'b0;
          r_eating[w_p]  <= 1'b1;
          r_may_eat[w_p] <= 1'b1;
        end
        if (r_k == LAST_K) r_rr <= wrap_add(r_rr, IDX_W'(1));
      end
    end
  end

`ifdef DPP_ARB_STATS_EN
  logic [15:0] r_grant_cnt;

  always_ff @(posedge clk) begin
    if (!reset)       r_grant_cnt <= '0;
    else if (w_grant) r_grant_cnt <= r_grant_cnt + 16'd1;
  end

  assign grant_cnt = r_grant_cnt;
`else
  assign grant_cnt = '0;
`endif

  assign evt_rden  = r_rden;
  assign may_eat   = r_may_eat;
  assign eating    = r_eating;
  assign fork_busy = w_fork_busy;
  assign err       = r_err;

endmodule

// File: tb/tb_fork_arbiter.sv
// Testbench for fork_arbiter: directed event sequences through a model FIFO,
// with a scoreboard of expected grants checked by a separate monitor.
module tb_fork_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       evt_empty;
  logic [2:0] evt_data = 3'b000;
  logic       evt_rden;
  logic [3:0] may_eat, eating, fork_busy;
  logic       err;
  logic [15:0] grant_cnt;

  logic       evt_empty3;
  logic [2:0] evt_data3 = 3'b111;
  logic       evt_rden3;
  logic [2:0] may_eat3, eating3, fork_busy3;
  logic       err3;
  logic [15:0] grant_cnt3;

  always #5 clk = ~clk;

  fork_arbiter #(.N_PHILO(4), .ID_W(2)) u_dut (
    .clk(clk), .reset(reset), .evt_empty(evt_empty), .evt_data(evt_data),
    .evt_rden(evt_rden), .may_eat(may_eat), .eating(eating),
    .fork_busy(fork_busy), .err(err), .grant_cnt(grant_cnt)
  );

  fork_arbiter #(.N_PHILO(3), .ID_W(2)) u_dut3 (
    .clk(clk), .reset(reset), .evt_empty(evt_empty3), .evt_data(evt_data3),
    .evt_rden(evt_rden3), .may_eat(may_eat3), .eating(eating3),
    .fork_busy(fork_busy3), .err(err3), .grant_cnt(grant_cnt3)
  );

  // Event FIFO model: data appears on the edge that consumes the read enable.
  logic [2:0] words [0:31];
  int wr_ptr = 0;
  int rd_ptr = 0;
  assign evt_empty = (wr_ptr == rd_ptr);

  always @(posedge clk) begin
    if (evt_rden && (wr_ptr != rd_ptr)) begin
      evt_data <= words[rd_ptr];
      rd_ptr   <= rd_ptr + 1;
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [3:0] me;
    logic [3:0] eat;
    int         lat;
  } exp_t;
  exp_t sb[$];

  int n_vec  = 0;
  int n_fail = 0;
  int rd_cyc = 0;
  int rd_gap = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [15:0] exp_cnt(input int n);
`ifdef DPP_ARB_STATS_EN
    return 16'(n);
`else
    return (n == 0) ? 16'd0 : 16'd0;
`endif
  endfunction

  task automatic push_evt(input logic [2:0] w);
    words[wr_ptr] = w;
    wr_ptr++;
  endtask

  // lat = cycles from the evt_rden cycle to the may_eat cycle (3 + scan slot).
  task automatic expect_grant(input logic [3:0] me, input logic [3:0] eat, input int lat);
    exp_t e;
    e.me = me; e.eat = eat; e.lat = lat;
    sb.push_back(e);
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // Monitor: pops the scoreboard on every grant pulse.
  exp_t m_e;
  always @(negedge clk) begin
    if (reset === 1'b1) begin
      if (evt_rden) begin
        rd_gap = cyc - rd_cyc;
        rd_cyc = cyc;
      end
      if (may_eat !== 4'b0000) begin
        if (sb.size() == 0) begin
          check("unexpected_may_eat", 32'(may_eat), 32'd0);
        end else begin
          m_e = sb.pop_front();
          check("may_eat", 32'(may_eat), 32'(m_e.me));
          check("eating_at_grant", 32'(eating), 32'(m_e.eat));
          check("grant_latency", 32'(cyc - rd_cyc), 32'(m_e.lat));
        end
      end
      if (may_eat3 !== 3'b000) check("dut3_may_eat", 32'(may_eat3), 32'd0);
    end
  end

  initial begin
    reset      = 1'b0;
    evt_empty3 = 1'b1;
    // Reset with a pending event: nothing may be read while reset is low.
    expect_grant(4'b0001, 4'b0001, 3);
    push_evt(3'b100);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("rst_rden", 32'(evt_rden), 32'd0);
      check("rst_may_eat", 32'(may_eat), 32'd0);
      check("rst_eating", 32'(eating), 32'd0);
      check("rst_fork_busy", 32'(fork_busy), 32'd0);
      check("rst_err", 32'(err), 32'd0);
      check("rst_grant_cnt", 32'(grant_cnt), 32'(exp_cnt(0)));
    end
    reset = 1'b1;
    check("idle_rden", 32'(evt_rden), 32'd0);
    @(negedge clk);
    check("read_rden", 32'(evt_rden), 32'd1);
    @(negedge clk);
    check("rden_pulse_end", 32'(evt_rden), 32'd0);
    wait_cycles(8);
    check("single_eating", 32'(eating), 32'h1);
    check("single_fork_busy", 32'(fork_busy), 32'h3);
    check("single_grant_cnt", 32'(grant_cnt), 32'(exp_cnt(1)));

    // Blocked: seat 1 needs fork 1, held by seat 0 (rr=1 this pass).
    push_evt(3'b101);
    wait_cycles(10);
    check("blocked_eating", 32'(eating), 32'h1);
    check("blocked_err", 32'(err), 32'd0);

    // Handoff: done/0 frees fork 1; rr=2 so seat 1 is slot k=3.
    expect_grant(4'b0010, 4'b0010, 6);
    push_evt(3'b000);
    wait_cycles(10);
    check("handoff_eating", 32'(eating), 32'h2);
    check("handoff_fork_busy", 32'(fork_busy), 32'h6);
    check("handoff_grant_cnt", 32'(grant_cnt), 32'(exp_cnt(2)));

    // Clear seat 1 (rr=3), leaving the table empty with rr back at 0.
    push_evt(3'b001);
    wait_cycles(10);
    check("clear_eating", 32'(eating), 32'h0);

    // Parallel grants, queued back to back: seat 0 at rr=0 k=0, seat 2 at rr=1 k=1.
    expect_grant(4'b0001, 4'b0001, 3);
    expect_grant(4'b0100, 4'b0101, 4);
    push_evt(3'b100);
    push_evt(3'b110);
    wait_cycles(18);
    check("parallel_eating", 32'(eating), 32'h5);
    check("parallel_fork_busy", 32'(fork_busy), 32'hF);
    check("parallel_grant_cnt", 32'(grant_cnt), 32'(exp_cnt(4)));
    check("b2b_rden_gap", 32'(rd_gap), 32'd7);
    check("parallel_err", 32'(err), 32'd0);

    // Protocol error: done/3 while seat 3 is not eating.
    push_evt(3'b011);
    wait_cycles(10);
    check("err_set", 32'(err), 32'd1);
    check("err_eating", 32'(eating), 32'h5);

    // A valid event after the error is still applied; err stays set.
    push_evt(3'b010);
    wait_cycles(10);
    check("post_err_eating", 32'(eating), 32'h1);
    check("post_err_fork_busy", 32'(fork_busy), 32'h3);
    check("err_sticky", 32'(err), 32'd1);

    // Full reset clears err and the tables.
    reset = 1'b0;
    wait_cycles(2);
    check("rst2_err", 32'(err), 32'd0);
    check("rst2_eating", 32'(eating), 32'h0);
    check("rst2_grant_cnt", 32'(grant_cnt), 32'(exp_cnt(0)));
    check("dut3_err_clear", 32'(err3), 32'd0);
    reset = 1'b1;

    // Reset mid-scan: hungry/1 would be granted in the second SCAN cycle.
    // The queued hungry/3 then runs with rr=0, so seat 3 is slot k=3.
    expect_grant(4'b1000, 4'b1000, 6);
    push_evt(3'b101);
    push_evt(3'b111);
    begin
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
        @(negedge clk);
        if (evt_rden) seen = 1'b1;
      end
      if (!seen) begin
        n_vec++;
        n_fail++;
        $display("FAIL midscan_rden_timeout: got no evt_rden within 20 cycles");
      end
    end
    wait_cycles(3);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    check("midscan_may_eat", 32'(may_eat), 32'd0);
    check("midscan_eating", 32'(eating), 32'h0);
    wait_cycles(12);
    check("resume_eating", 32'(eating), 32'h8);
    check("resume_fork_busy", 32'(fork_busy), 32'h9);
    check("resume_grant_cnt", 32'(grant_cnt), 32'(exp_cnt(1)));
    check("resume_fifo_drained", 32'(rd_ptr), 32'(wr_ptr));

    // ID error on a 3-seat table: event 3'b111 names seat 3.
    evt_empty3 = 1'b0;
    @(negedge clk);
    evt_empty3 = 1'b1;
    wait_cycles(10);
    check("dut3_id_err", 32'(err3), 32'd1);
    check("dut3_eating", 32'(eating3), 32'h0);

    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
